speed_ctrl_divider: RTL and testbench
=====================================

// Module: speed_ctrl_divider
// PURPOSE
//  Parametrised successor to the lab speed controller.
//  - Holds a playback-rate divisor (clk_count), adjusted by speed_up/speed_down buttons.
//  - Buttons are edge-detected, with optional auto-repeat; the divisor saturates at MIN/MAX.
//  - Generates a one-cycle rate tick every clk_count cycles. The tick drives the audio/flash
//    sample-fetch FSM, replacing that FSM's local divider.
// PARAMETERS
//  WIDTH          32     width of divisor and tick counter
//  DEFAULT_COUNT  1136   divisor after reset (50 MHz / ~44 kHz)
//  STEP           16     divisor change per step
//  MIN_COUNT      16     lowest legal divisor (fastest); MIN_COUNT >= 2
//  MAX_COUNT      65535  highest legal divisor (slowest); MIN<=DEFAULT<=MAX < 2**WIDTH
//  REPEAT_CYCLES  0      auto-repeat period in cycles while held; 0 = disabled
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  speed_up    in   1      level, pre-synchronised; decreases divisor
//  speed_down  in   1      level, pre-synchronised; increases divisor
//  clk_count   out  WIDTH  current divisor (registered)
//  tick        out  1      one-cycle pulse every clk_count cycles
//  at_min      out  1      clk_count == MIN_COUNT
//  at_max      out  1      clk_count == MAX_COUNT
// BEHAVIOUR
//  Reset: synchronous, active-high; has priority over everything else.
//   - clk_count=DEFAULT_COUNT, tick=0, tick counter=0, hold counter=0.
//   - at_min/at_max reflect DEFAULT_COUNT.
//   - Button history regs load the current button levels, so a button held through reset
//     gives no step when reset releases.
//  Edge detect: rise_x = x & ~x_q.
//   - The divisor updates on the same edge that first samples x high; new value is visible
//     the next cycle.
//  Step resolution, per edge, exactly one of:
//   - rise_up & rise_down, or both levels high: no step; hold counter cleared.
//   - up step:   clk_count = max(clk_count-STEP, MIN_COUNT). Compute in WIDTH+1 bits; no underflow.
//   - down step: clk_count = min(clk_count+STEP, MAX_COUNT). Compute in WIDTH+1 bits; no wrap.
//  Auto-repeat (REPEAT_CYCLES>0), hold counter:
//   - Cleared on the initial rising-edge step.
//   - Increments each cycle exactly one button stays high.
//   - On reaching REPEAT_CYCLES-1: one more step of that direction, then counter clears.
//   - Release or both-high clears it. With REPEAT_CYCLES=0 only edges step.
//  Tick counter cnt:
//   - Compare: if cnt >= clk_count-1 then tick=1 (registered), cnt=0; else cnt+1, tick=0.
//   - Period = clk_count cycles; first tick on cycle clk_count-1 after reset release.
//   - Divisor shrinks below cnt: tick fires on the next cycle; no lost or runaway count.
//   - Divisor grows: current period extends to the new value.
//  Saturation: stepping at a limit leaves clk_count unchanged; the flag stays 1.
//  at_min/at_max are registered alongside clk_count (same-cycle consistent).
// TESTING  (bench params: WIDTH=8 DEFAULT=8 STEP=2 MIN=4 MAX=12 REPEAT=5)
//  1. Release reset, no buttons -> clk_count=8; tick at cycles 7,15,23; at_min=at_max=0.
//  2. speed_up high 4 cycles then low -> clk_count 8->6 once; no repeat; tick period becomes 6.
//  3. speed_down held 11 cycles -> steps at cycles 0,5,10: 10, 12, 12; at_max=1 from 2nd step.
//  4. Three separate 1-cycle speed_up pulses from 8 -> 6,4,4; at_min=1; no underflow.
//  5. speed_up & speed_down rise same cycle -> clk_count stays 8; no repeat while both held.
//  6. cnt=7 with divisor 8, pulse speed_up (->6) -> tick on next cycle, then every 6.
//  7. Reset at cnt=5 with speed_down held through release -> clk_count=8, cnt=0, no step after.

Source files
------------

// File: rtl/speed_ctrl_divider.sv
// Playback-rate divisor with button stepping, auto-repeat and saturation,
// plus a rate tick generator that fires once every clk_count cycles.
module speed_ctrl_divider #(
  parameter int WIDTH         = 32,
  parameter int DEFAULT_COUNT = 1136,
  parameter int STEP          = 16,
  parameter int MIN_COUNT     = 16,
  parameter int MAX_COUNT     = 65535,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             speed_up,
  input  logic             speed_down,
  output logic [WIDTH-1:0] clk_count,
  output logic             tick,
  output logic             at_min,
  output logic             at_max
);

  localparam int HW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MIN_W  = (WIDTH+1)'(MIN_COUNT);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] DEF  = WIDTH'(DEFAULT_COUNT);

  logic             up_q;
  logic             dn_q;
  logic [HW-1:0]    hold;
  logic [HW-1:0]    nxt_hold;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt_count;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   dn_sum;
  logic             rise_up;
  logic             rise_dn;
  logic             both;
  logic             do_up;
  logic             do_dn;

  assign rise_up = speed_up & ~up_q;
  assign rise_dn = speed_down & ~dn_q;
  assign both    = (rise_up & rise_dn) | (speed_up & speed_down);
  assign ext     = {1'b0, clk_count};
  assign dn_sum  = ext + STEP_W;

  always_comb begin
    do_up    = 1'b0;
    do_dn    = 1'b0;
    nxt_hold = '0;
    if (both) begin
      nxt_hold = '0;
    end else if (rise_up) begin
      do_up = 1'b1;
    end else if (rise_dn) begin
      do_dn = 1'b1;
    end else if (REPEAT_CYCLES > 0 && (speed_up ^ speed_down)) begin
      if (hold == HOLD_LAST) begin
        do_up = speed_up;
        do_dn = speed_down;
      end else begin
        nxt_hold = hold + 1'b1;
      end
    end
  end

  // Saturating arithmetic is done one bit wider so neither limit can wrap.
  always_comb begin
    nxt_count = clk_count;
    unique case (1'b1)
      do_up: begin
        if (ext < MIN_W + STEP_W) nxt_count = MIN_W[WIDTH-1:0];
        else nxt_count = clk_count - STEP_W[WIDTH-1:0];
      end
      do_dn: begin
        if (dn_sum > MAX_W) nxt_count = MAX_W[WIDTH-1:0];
        else nxt_count = dn_sum[WIDTH-1:0];
      end
      default: nxt_count = clk_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_count <= DEF;
      at_min    <= (DEFAULT_COUNT == MIN_COUNT);
      at_max    <= (DEFAULT_COUNT == MAX_COUNT);
      tick      <= 1'b0;
      cnt       <= '0;
      hold      <= '0;
      up_q      <= speed_up;
      dn_q      <= speed_down;
    end else begin
      up_q      <= speed_up;
      dn_q      <= speed_down;
      hold      <= nxt_hold;
      clk_count <= nxt_count;
      at_min    <= ({1'b0, nxt_count} == MIN_W);
      at_max    <= ({1'b0, nxt_count} == MAX_W);
      // >= rather than == so a shrinking divisor cannot strand cnt above it.
      if (cnt >= clk_count - 1'b1) begin
        tick <= 1'b1;
        cnt  <= '0;
      end else begin
        tick <= 1'b0;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_speed_ctrl_divider.sv
// Randomised and directed bench for speed_ctrl_divider with a queue
// scoreboard fed by a behavioural model of the divisor and tick timing.
module tb_speed_ctrl_divider;

  localparam int W    = 8;
  localparam int DEF  = 8;
  localparam int STP  = 2;
  localparam int MINC = 4;
  localparam int MAXC = 12;
  localparam int REP  = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         speed_up = 1'b0;
  logic         speed_down = 1'b0;
  logic [W-1:0] clk_count;
  logic         tick;
  logic         at_min;
  logic         at_max;

  speed_ctrl_divider #(
    .WIDTH(W), .DEFAULT_COUNT(DEF), .STEP(STP),
    .MIN_COUNT(MINC), .MAX_COUNT(MAXC), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset),
    .speed_up(speed_up), .speed_down(speed_down),
    .clk_count(clk_count), .tick(tick),
    .at_min(at_min), .at_max(at_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cc;
    bit tk;
    bit mn;
    bit mx;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_div = DEF;
  int m_since = 0;
  int m_held = 0;
  bit m_pu = 0;
  bit m_pd = 0;
  bit m_tick = 0;

  task automatic model_edge(input bit r, input bit u, input bit d);
    exp_t e;
    int dir;
    if (r) begin
      m_div = DEF; m_since = 0; m_held = 0; m_tick = 0;
    end else begin
      // Tick: a period of m_div edges, measured with the pre-edge divisor.
      if (m_since + 1 >= m_div) begin
        m_tick = 1; m_since = 0;
      end else begin
        m_tick = 0; m_since++;
      end
      dir = 0;
      if ((u && !m_pu && d && !m_pd) || (u && d)) begin
        m_held = 0;
      end else if (u && !m_pu) begin
        dir = -1; m_held = 0;
      end else if (d && !m_pd) begin
        dir = 1; m_held = 0;
      end else if (u != d) begin
        m_held++;
        if (m_held == REP) begin
          dir = u ? -1 : 1; m_held = 0;
        end
      end else begin
        m_held = 0;
      end
      if (dir < 0) m_div = (m_div - STP < MINC) ? MINC : m_div - STP;
      if (dir > 0) m_div = (m_div + STP > MAXC) ? MAXC : m_div + STP;
    end
    m_pu = u;
    m_pd = d;
    e.cc = m_div;
    e.tk = m_tick;
    e.mn = (m_div == MINC);
    e.mx = (m_div == MAXC);
    q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit u, input bit d);
    @(negedge clk);
    reset = r;
    speed_up = u;
    speed_down = d;
    model_edge(r, u, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  // Monitor: every edge produces one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (clk_count !== W'(e.cc) || tick !== e.tk ||
            at_min !== e.mn || at_max !== e.mx) begin
          miscompares++;
          $display("FAIL vec%0d got cc=%0d tick=%b min=%b max=%b want cc=%0d tick=%b min=%b max=%b",
                   vectors, clk_count, tick, at_min, at_max,
                   e.cc, e.tk, e.mn, e.mx);
        end
      end
    end
  end

  initial begin
    bit u, d, r;
    int budget;
    // 1: idle after reset
    cyc(1, 0, 0); cyc(1, 0, 0);
    idle(26);
    // 2: speed_up held 4 cycles
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    idle(20);
    // 3: speed_down held 11 cycles from 8
    cyc(1, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1);
    idle(15);
    // 4: three single-cycle up pulses
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0); cyc(0, 0, 0); end
    idle(10);
    // 5: simultaneous rise, held
    cyc(1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 1);
    idle(10);
    // 6: pulse up when cnt reaches 7 with divisor 8
    cyc(1, 0, 0);
    idle(7);
    cyc(0, 1, 0);
    idle(14);
    // 7: reset at cnt=5 with speed_down held through release
    cyc(1, 0, 0);
    idle(5);
    cyc(1, 0, 1); cyc(1, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    idle(12);
    // Random: sticky buttons, occasional reset
    u = 0; d = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) u = ~u;
      if ($urandom_range(0, 11) == 0) d = ~d;
      r = ($urandom_range(0, 299) == 0);
      cyc(r, u, d);
    end
    idle(2);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
